// File: rtl/duart_tx_sched_pkg.sv
// Shared DUART register map, status bit positions and scheduler state type
// for the transmit scheduler.
package duart_pkg;

  localparam logic [3:0] ADDR_SRA     = 4'h1;
  localparam logic [3:0] ADDR_THR     = 4'h3;
  localparam logic [3:0] ADDR_RHR     = 4'h3;
  localparam logic [3:0] ADDR_IMR     = 4'h5;
  localparam logic [3:0] ADDR_ISR     = 4'h5;
  localparam logic [3:0] ADDR_IPR     = 4'hD;
  localparam logic [3:0] ADDR_OPR_SET = 4'hE;
  localparam logic [3:0] ADDR_OPR_CLR = 4'hF;

  localparam int unsigned TXRDY_BIT = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CPU   = 2'd1,
    ST_POLL  = 2'd2,
    ST_WRITE = 2'd3
  } state_e;

endpackage

// File: rtl/duart_tx_sched_if.sv
// Bus bundle for the scheduler: CPU request port, transmit queue port and
// DUART register master port. The master modport is the surrounding system.
interface duart_tx_sched_if #(
  parameter int DEPTH = 16
);
  localparam int LW = $clog2(DEPTH) + 1;

  logic          cpu_req;
  logic          cpu_we;
  logic [3:0]    cpu_addr;
  logic [7:0]    cpu_di;
  logic [7:0]    cpu_do;
  logic          cpu_ack;

  logic          q_valid;
  logic [7:0]    q_data;
  logic          q_ready;
  logic [LW-1:0] q_level;

  logic          duart_enable;
  logic          duart_we;
  logic [3:0]    duart_addr;
  logic [7:0]    duart_di;
  logic [7:0]    duart_do;

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_di,
    input  cpu_do, cpu_ack,
    output q_valid, q_data,
    input  q_ready, q_level,
    input  duart_enable, duart_we, duart_addr, duart_di,
    output duart_do
  );

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_di,
    output cpu_do, cpu_ack,
    input  q_valid, q_data,
    output q_ready, q_level,
    output duart_enable, duart_we, duart_addr, duart_di,
    input  duart_do
  );

endinterface

// File: rtl/duart_tx_sched_fifo.sv
// Byte queue feeding the transmit sequencer; full/empty/level are registered so
// a push can never sneak in on the same cycle a pop frees a slot.
module duart_tx_fifo #(
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [7:0]               wdata_i,
  output logic [7:0]               rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   level_o
);
  localparam int AW = $clog2(DEPTH);

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]   level_q, level_d;
  logic          full_q, full_d, empty_q, empty_d;
  logic          push_ok, pop_ok;

  assign push_ok = push_i && !full_q;
  assign pop_ok  = pop_i && !empty_q;

  // pointer and occupancy update; pointers wrap naturally at the power-of-two depth
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push_ok) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    if (push_ok && !pop_ok) begin
      level_d = level_q + (AW+1)'(1);
    end else if (pop_ok && !push_ok) begin
      level_d = level_q - (AW+1)'(1);
    end else begin
      level_d = level_q;
    end
    full_d  = (level_d == (AW+1)'(DEPTH));
    empty_d = (level_d == (AW+1)'(0));
  end

  // control state
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
    end
  end

  // storage
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign full_o  = full_q;
  assign empty_o = empty_q;
  assign level_o = level_q;

endmodule

// File: rtl/duart_tx_sched.sv
// Arbitrates the DUART register port between the CPU and a sequencer draining
// the TX queue into channel A. DUART_TX_SCHED_STATS_EN enables the tx_count counter.
module duart_tx_sched
  import duart_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            clken,
  duart_tx_sched_if.slave bus,
  output logic            busy,
  output logic [15:0]     tx_count
);
  localparam int LW = $clog2(DEPTH) + 1;

  state_e        state_q, state_d;
  logic          last_seq_q, last_seq_d;
  logic          en_q, en_d, we_q, we_d;
  logic [3:0]    addr_q, addr_d;
  logic [7:0]    di_q, di_d;
  logic [7:0]    cpu_do_q, cpu_do_d;
  logic          cpu_ack_q, cpu_ack_d;
  logic          fifo_full, fifo_empty, pop_s;
  logic [7:0]    fifo_head;
  logic [LW-1:0] fifo_level;

  assign pop_s = clken && (state_q == ST_WRITE);

  duart_tx_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push_i  (bus.q_valid),
    .pop_i   (pop_s),
    .wdata_i (bus.q_data),
    .rdata_o (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (fifo_level)
  );

  // state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      last_seq_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      last_seq_q <= last_seq_d;
    end
  end

  // next state; the CPU wins IDLE unless it had the previous grant and the queue waits
  always_comb begin
    state_d    = state_q;
    last_seq_d = last_seq_q;
    if (clken) begin
      case (state_q)
        ST_IDLE: begin
          if (bus.cpu_req && (fifo_empty || last_seq_q)) begin
            state_d    = ST_CPU;
            last_seq_d = 1'b0;
          end else if (!fifo_empty) begin
            state_d    = ST_POLL;
            last_seq_d = 1'b1;
          end else begin
            state_d    = ST_IDLE;
          end
        end
        ST_CPU:   state_d = ST_IDLE;
        ST_POLL: begin
          if (bus.duart_do[TXRDY_BIT]) begin
            state_d = ST_WRITE;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_WRITE: state_d = ST_IDLE;
        default:  state_d = ST_IDLE;
      endcase
    end else begin
      state_d    = state_q;
      last_seq_d = last_seq_q;
    end
  end

  // DUART port values for the state being entered; CPU fields are captured at grant
  always_comb begin
    en_d   = en_q;
    we_d   = we_q;
    addr_d = addr_q;
    di_d   = di_q;
    if (clken) begin
      case (state_d)
        ST_CPU: begin
          en_d   = 1'b1;
          we_d   = bus.cpu_we;
          addr_d = bus.cpu_addr;
          di_d   = bus.cpu_di;
        end
        ST_POLL: begin
          en_d   = 1'b1;
          we_d   = 1'b0;
          addr_d = ADDR_SRA;
          di_d   = 8'h00;
        end
        ST_WRITE: begin
          en_d   = 1'b1;
          we_d   = 1'b1;
          addr_d = ADDR_THR;
          di_d   = fifo_head;
        end
        default: begin
          en_d   = 1'b0;
          we_d   = 1'b0;
          addr_d = 4'h0;
          di_d   = 8'h00;
        end
      endcase
    end else begin
      en_d   = en_q;
      we_d   = we_q;
      addr_d = addr_q;
      di_d   = di_q;
    end
    cpu_ack_d = clken && (state_q == ST_CPU);
    if (clken && (state_q == ST_CPU) && !we_q) begin
      cpu_do_d = bus.duart_do;
    end else begin
      cpu_do_d = cpu_do_q;
    end
  end

  // registered outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      en_q      <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= 4'h0;
      di_q      <= 8'h00;
      cpu_do_q  <= 8'h00;
      cpu_ack_q <= 1'b0;
    end else begin
      en_q      <= en_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      di_q      <= di_d;
      cpu_do_q  <= cpu_do_d;
      cpu_ack_q <= cpu_ack_d;
    end
  end

`ifdef DUART_TX_SCHED_STATS_EN
  logic [15:0] tx_count_q, tx_count_d;

  // bytes handed to THR, wrapping at 16 bits
  always_comb begin
    if (pop_s) begin
      tx_count_d = tx_count_q + 16'd1;
    end else begin
      tx_count_d = tx_count_q;
    end
  end

  // transmit counter register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tx_count_q <= 16'h0000;
    end else begin
      tx_count_q <= tx_count_d;
    end
  end

  assign tx_count = tx_count_q;
`else
  assign tx_count = 16'h0000;
`endif

  assign bus.duart_enable = en_q;
  assign bus.duart_we     = we_q;
  assign bus.duart_addr   = addr_q;
  assign bus.duart_di     = di_q;
  assign bus.cpu_do       = cpu_do_q;
  assign bus.cpu_ack      = cpu_ack_q;
  assign bus.q_ready      = !fifo_full;
  assign bus.q_level      = fifo_level;
  assign busy             = (state_q != ST_IDLE) || !fifo_empty;

endmodule

// File: tb/tb_duart_tx_sched.sv
// Directed bench for duart_tx_sched: a transaction-level model of the port
// arbitration is compared against the DUT every cycle, plus literal checks.
module tb_duart_tx_sched;
  localparam int DEPTH = 16;
`ifdef DUART_TX_SCHED_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        clken;
  logic        busy;
  logic [15:0] tx_count;
  bit          txrdy;

  duart_tx_sched_if #(.DEPTH(DEPTH)) bus ();

  duart_tx_sched #(.DEPTH(DEPTH)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .clken    (clken),
    .bus      (bus),
    .busy     (busy),
    .tx_count (tx_count)
  );

  always #5 clk = ~clk;

  // bench-side DUART: SRA reports TxRDY, IPR returns 0x55, everything else 0
  function automatic logic [7:0] resp(input logic [3:0] a, input bit rdy);
    if (a == 4'hD) return 8'h55;
    else if (a == 4'h1) return {5'b00000, rdy, 2'b00};
    else return 8'h00;
  endfunction
  assign bus.duart_do = resp(bus.duart_addr, txrdy);

  int n_checks = 0;
  int n_err = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---- transaction-level model: which access owns the port, queue contents ----
  typedef enum int {A_NONE, A_CPU, A_POLL, A_WRITE} acc_e;
  acc_e       acc;
  bit         cpu_turn_used;   // 1 when the sequencer had the most recent grant
  bit         lat_we;
  logic [3:0] lat_addr;
  logic [7:0] lat_di;
  logic [7:0] mq[$];
  logic [7:0] m_do;
  bit         m_ack;
  int         m_tx;
  bit         was_empty, was_full;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc = A_NONE; mq.delete(); cpu_turn_used = 1'b1;
      m_do = 8'h00; m_ack = 1'b0; m_tx = 0;
    end else begin
      was_empty = (mq.size() == 0);
      was_full  = (mq.size() == DEPTH);
      m_ack = 1'b0;
      if (clken) begin
        case (acc)
          A_CPU: begin
            m_ack = 1'b1;
            if (!lat_we) m_do = resp(lat_addr, txrdy);
            acc = A_NONE;
          end
          A_POLL:  acc = txrdy ? A_WRITE : A_NONE;
          A_WRITE: begin
            void'(mq.pop_front());
            m_tx = (m_tx + 1) % 65536;
            acc = A_NONE;
          end
          default: begin
            if (bus.cpu_req && (was_empty || cpu_turn_used)) begin
              acc = A_CPU; cpu_turn_used = 1'b0;
              lat_we = bus.cpu_we; lat_addr = bus.cpu_addr; lat_di = bus.cpu_di;
            end else if (!was_empty) begin
              acc = A_POLL; cpu_turn_used = 1'b1;
            end
          end
        endcase
      end
      if (bus.q_valid && !was_full) mq.push_back(bus.q_data);
    end
  end

  // ---- per-cycle compare against the model ----
  logic       e_en, e_we;
  logic [3:0] e_addr;
  logic [7:0] e_di;
  always @(negedge clk) begin
    e_en   = (acc != A_NONE);
    e_we   = (acc == A_WRITE) || (acc == A_CPU && lat_we);
    e_addr = (acc == A_CPU) ? lat_addr : (acc == A_POLL) ? 4'h1 : 4'h3;
    e_di   = (acc == A_CPU) ? lat_di : (acc == A_WRITE) ? mq[0] : 8'h00;
    chk("duart_enable", bus.duart_enable, e_en);
    chk("duart_we", bus.duart_we, e_we);
    if (e_en) begin
      chk("duart_addr", bus.duart_addr, e_addr);
      chk("duart_di", bus.duart_di, e_di);
    end
    chk("cpu_ack", bus.cpu_ack, m_ack);
    chk("cpu_do", bus.cpu_do, m_do);
    chk("q_ready", bus.q_ready, mq.size() < DEPTH);
    chk("q_level", bus.q_level, mq.size());
    chk("busy", busy, (acc != A_NONE) || (mq.size() != 0));
    chk("tx_count", tx_count, STATS ? m_tx : 0);
  end

  // ---- observers of what the DUT actually did ----
  logic [7:0] thr_log[$];
  int n_polls = 0, n_acks = 0, cyc = 0, last_ack = -1, max_gap = 0;
  bit gap_en = 1'b0;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (reset_n && clken && bus.duart_enable && bus.duart_we && bus.duart_addr == 4'h3)
      thr_log.push_back(bus.duart_di);
    if (reset_n && clken && bus.duart_enable && !bus.duart_we && bus.duart_addr == 4'h1)
      n_polls <= n_polls + 1;
  end
  always @(negedge clk) begin
    if (bus.cpu_ack) begin
      n_acks <= n_acks + 1;
      if (gap_en && last_ack >= 0 && cyc - last_ack > max_gap) max_gap <= cyc - last_ack;
      last_ack <= cyc;
    end
  end

  // ---- stimulus helpers ----
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic push_byte(input logic [7:0] b);
    bus.q_valid = 1'b1; bus.q_data = b;
    tick();
    bus.q_valid = 1'b0;
  endtask

  task automatic wait_idle(input string nm, input int lim);
    bit ok = 1'b0;
    for (int i = 0; i < lim; i++) begin
      tick();
      if (!busy) begin ok = 1'b1; break; end
    end
    chk(nm, ok, 1);
  endtask

  task automatic wait_polls(input string nm, input int target, input int lim);
    bit ok = 1'b0;
    for (int i = 0; i < lim; i++) begin
      if (n_polls >= target) begin ok = 1'b1; break; end
      tick();
    end
    chk(nm, ok, 1);
  endtask

  task automatic wait_access(input string nm, input bit we, input logic [3:0] a, input int lim);
    bit ok = 1'b0;
    for (int i = 0; i < lim; i++) begin
      if (bus.duart_enable && bus.duart_we == we && bus.duart_addr == a) begin ok = 1'b1; break; end
      tick();
    end
    chk(nm, ok, 1);
  endtask

  task automatic cpu_access(input string nm, input bit we, input logic [3:0] a, input logic [7:0] d);
    bit ok = 1'b0;
    bus.cpu_req = 1'b1; bus.cpu_we = we; bus.cpu_addr = a; bus.cpu_di = d;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (bus.cpu_ack) begin ok = 1'b1; break; end
    end
    bus.cpu_req = 1'b0;
    chk(nm, ok, 1);
  endtask

  int base, acks0, k;
  bit ok_order, ok_loop;

  initial begin
    clken = 1'b1; txrdy = 1'b0;
    bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = 4'h0; bus.cpu_di = 8'h00;
    bus.q_valid = 1'b0; bus.q_data = 8'h00;
    #2 reset_n = 1'b0;
    repeat (3) tick();
    chk("rst_q_ready", bus.q_ready, 1);
    chk("rst_q_level", bus.q_level, 0);
    chk("rst_busy", busy, 0);
    chk("rst_enable", bus.duart_enable, 0);
    chk("rst_cpu_do", bus.cpu_do, 0);
    chk("rst_tx_count", tx_count, 0);
    reset_n = 1'b1;
    tick();

    // two bytes drained back to back
    txrdy = 1'b1;
    push_byte(8'h41);
    push_byte(8'h42);
    wait_idle("t1_drain", 40);
    chk("t1_thr_count", thr_log.size(), 2);
    chk("t1_thr0", thr_log[0], 8'h41);
    chk("t1_thr1", thr_log[1], 8'h42);
    chk("t1_tx_count", tx_count, STATS ? 2 : 0);
    chk("t1_busy", busy, 0);

    // CPU read slips in between failing polls
    txrdy = 1'b0;
    base = thr_log.size();
    push_byte(8'h61);
    wait_polls("t2_polls_a", n_polls + 2, 30);
    acks0 = n_acks;
    cpu_access("t2_ack_seen", 1'b0, 4'hD, 8'h00);
    chk("t2_cpu_do", bus.cpu_do, 8'h55);
    wait_polls("t2_polls_b", 5, 40);
    repeat (4) tick();
    chk("t2_single_ack", n_acks, acks0 + 1);
    chk("t2_no_thr_while_busy", thr_log.size(), base);
    txrdy = 1'b1;
    wait_idle("t2_drain", 30);
    chk("t2_thr_count", thr_log.size(), base + 1);
    chk("t2_thr_data", thr_log[thr_log.size() - 1], 8'h61);

    // clken stalled for 10 cycles mid-poll
    txrdy = 1'b0;
    push_byte(8'h62);
    wait_access("t3_poll_seen", 1'b0, 4'h1, 20);
    clken = 1'b0;
    repeat (10) tick();
    chk("t3_hold_en", bus.duart_enable, 1);
    chk("t3_hold_addr", bus.duart_addr, 4'h1);
    txrdy = 1'b1;
    clken = 1'b1;
    wait_idle("t3_drain", 30);
    chk("t3_thr_data", thr_log[thr_log.size() - 1], 8'h62);

    // continuous CPU writes alternate with the sequencer
    base = thr_log.size();
    push_byte(8'h71); push_byte(8'h72); push_byte(8'h73);
    max_gap = 0; last_ack = -1; gap_en = 1'b1;
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = 4'hE; bus.cpu_di = 8'hA5;
    k = 0; ok_loop = 1'b0;
    for (int i = 0; i < 80; i++) begin
      tick();
      if (bus.cpu_ack) k++;
      if (k >= 6) begin ok_loop = 1'b1; break; end
    end
    bus.cpu_req = 1'b0;
    chk("t4_six_acks", ok_loop, 1);
    wait_idle("t4_drain", 30);
    gap_en = 1'b0;
    chk("t4_max_ack_gap", max_gap, 5);
    chk("t4_thr_count", thr_log.size(), base + 3);
    chk("t4_thr_last", thr_log[thr_log.size() - 1], 8'h73);

    // overfill: 17 offered, 16 accepted, order kept
    txrdy = 1'b0;
    base = thr_log.size();
    for (int i = 0; i < DEPTH + 1; i++) begin
      bus.q_valid = 1'b1; bus.q_data = 8'(8'h10 + i);
      tick();
    end
    bus.q_valid = 1'b0;
    chk("t5_level_full", bus.q_level, DEPTH);
    chk("t5_q_ready", bus.q_ready, 0);
    txrdy = 1'b1;
    wait_idle("t5_drain", DEPTH * 4 + 20);
    chk("t5_thr_count", thr_log.size(), base + DEPTH);
    ok_order = 1'b1;
    for (int i = 0; i < DEPTH; i++)
      if (thr_log[base + i] != 8'(8'h10 + i)) ok_order = 1'b0;
    chk("t5_order", ok_order, 1);

    // reset asserted in the middle of a THR write
    base = thr_log.size();
    acks0 = n_acks;
    push_byte(8'h77);
    wait_access("t6_write_seen", 1'b1, 4'h3, 20);
    #2 reset_n = 1'b0;
    #1;
    chk("t6_enable_async", bus.duart_enable, 0);
    chk("t6_level", bus.q_level, 0);
    chk("t6_tx_count", tx_count, 0);
    repeat (2) tick();
    reset_n = 1'b1;
    repeat (3) tick();
    chk("t6_no_thr", thr_log.size(), base);
    chk("t6_no_ack", n_acks, acks0);
    chk("t6_busy", busy, 0);

    repeat (2) tick();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
